// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory loader.
//               It holds the loader state encoding, the frame geometry (bytes
//               per instruction word and per length header) and the
//               instruction word width.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam int c_WORD_BYTES = 4;   // payload bytes per instruction word
  localparam int c_LEN_BYTES  = 2;   // bytes in the word-count header
  localparam int c_INSTR_W    = 32;  // instruction word width

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input and instruction-memory write port of the
//               loader, bundled together.
//   in_data/in_valid/in_ready : host byte stream (valid/ready handshake)
//   mem_we/mem_addr/mem_wdata : one-cycle word write into instruction memory
//   modport master : the loader (consumes bytes, drives memory writes)
//   modport slave  : the environment (host feeding bytes, memory receiving)
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [c_INSTR_W-1:0]  mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_byte_packer
// Description : Four-lane little-endian byte accumulator. Bytes are written
//               into the lane chosen by the caller; writing lane 3 completes
//               the word, which appears on `word` one cycle later together
//               with a one-cycle `word_valid` pulse (suppressed when
//               `word_en` is low, so out-of-range words never pulse).
// Ports       :
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : synchronous clear of lanes and outputs
//   byte_we    : write byte_in into lane `lane` this cycle
//   lane       : target lane, 0 = least significant byte
//   byte_in    : byte to store
//   word_en    : allow word_valid for the word being completed
//   word       : last completed word (registered)
//   word_valid : one-cycle pulse when `word` has just been completed
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 clear,
  input  wire logic                 byte_we,
  input  wire logic [1:0]           lane,
  input  wire logic [7:0]           byte_in,
  input  wire logic                 word_en,
  output logic      [c_INSTR_W-1:0] word,
  output logic                      word_valid
);

  // Lanes 0..2 are held here; lane 3 goes straight into the output word.
  logic [23:0]          r_low;
  logic [c_INSTR_W-1:0] r_word;
  logic                 r_word_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (clear) begin
      r_low        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (byte_we) begin
        case (lane)
          2'd0: r_low[7:0]   <= byte_in;
          2'd1: r_low[15:8]  <= byte_in;
          2'd2: r_low[23:16] <= byte_in;
          default: begin
            r_word       <= {byte_in, r_low};
            r_word_valid <= word_en;
          end
        endcase
      end
    end
  end

  assign word       = r_word;
  assign word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Writer side of the instruction memory. Receives a framed
//               byte stream (16-bit LE word count N, then 4*N payload bytes,
//               each word LSB first), writes words at consecutive addresses
//               and holds the core in reset until the image is complete.
// Ports       :
//   clk, rst     : clock, asynchronous active-high reset
//   restart      : one-cycle pulse, re-arms the loader (wins over a byte)
//   bus          : imem_loader_if.master (byte stream + memory write port)
//   cpu_hold     : high keeps the core in reset
//   done         : image fully received
//   overflow     : header count exceeded DEPTH (sticky until restart/rst)
//   checksum_err : (IMEM_LOADER_CHECKSUM_EN only) trailing XOR byte mismatch
// Options     : `define IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte
//               (XOR of header and payload) and the checksum_err output.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
)(
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   restart,
  imem_loader_if.master bus,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic        checksum_err,
`endif
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow
);

  localparam int c_LEN_W = 8 * c_LEN_BYTES;

  state_t               r_state;
  logic                 r_in_ready;
  logic                 r_cpu_hold;
  logic                 r_done;
  logic                 r_overflow;
  logic [7:0]           r_len_lo;
  logic [c_LEN_W-1:0]   r_len;
  logic [15:0]          r_word_idx;
  logic [1:0]           r_byte_cnt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]           r_csum;
  logic                 r_checksum_err;
`endif

  logic                 w_accept;
  logic [c_LEN_W-1:0]   w_len;
  logic                 w_last_lane;
  logic [15:0]          w_idx_next;
  logic                 w_word_en;
  logic                 w_pack_we;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_len       = {bus.in_data, r_len_lo};
  assign w_last_lane = (r_byte_cnt == 2'(c_WORD_BYTES - 1));
  assign w_idx_next  = r_word_idx + 16'd1;
  assign w_word_en   = ({16'd0, r_word_idx} < 32'(DEPTH));
  // restart drops any byte presented in the same cycle
  assign w_pack_we   = w_accept && (r_state == DATA) && !restart;

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .byte_we    (w_pack_we),
    .lane       (r_byte_cnt),
    .byte_in    (bus.in_data),
    .word_en    (w_word_en),
    .word       (bus.mem_wdata),
    .word_valid (bus.mem_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LEN_LO;
      r_in_ready <= 1'b1;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_mem_addr <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum         <= '0;
      r_checksum_err <= 1'b0;
`endif
    end else if (restart) begin
      r_state    <= LEN_LO;
      r_in_ready <= 1'b1;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_len_lo   <= '0;
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum         <= '0;
      r_checksum_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        LEN_LO: begin
          if (w_accept) begin
            r_len_lo <= bus.in_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum   <= bus.in_data;
`endif
            r_state  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (w_accept) begin
            r_len      <= w_len;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.in_data;
`endif
            if ({16'd0, w_len} > 32'(DEPTH)) begin
              r_overflow <= 1'b1;
            end
            if (w_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= CHK;
`else
              r_state    <= DONE;
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
`endif
            end else begin
              r_state <= DATA;
            end
          end
        end

        DATA: begin
          if (w_accept) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.in_data;
`endif
            if (w_last_lane) begin
              // Address is captured alongside the packer's word so both
              // appear on the write port in the same cycle.
              r_mem_addr <= r_word_idx[ADDR_WIDTH-1:0];
              r_word_idx <= w_idx_next;
              if (w_idx_next == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                r_state    <= CHK;
`else
                r_state    <= DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_accept) begin
            r_state    <= DONE;
            r_in_ready <= 1'b0;
            r_done     <= 1'b1;
            if (bus.in_data != r_csum) begin
              r_checksum_err <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          // Release one cycle after entry so the final write has landed;
          // a checksum error keeps the core held.
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (!r_checksum_err) begin
            r_cpu_hold <= 1'b0;
          end
`else
          r_cpu_hold <= 1'b0;
`endif
        end

        default: begin
          r_state <= LEN_LO;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.mem_addr = r_mem_addr;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign overflow     = r_overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum_err = r_checksum_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Frames are built as
//               byte queues; the expected write list is derived from the
//               frame bytes directly (word i = bytes 4i+2..4i+5, written
//               only for i < min(N, DEPTH)). A monitor records every byte
//               handshake and every memory write with a cycle stamp.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic restart;
  logic cpu_hold;
  logic done;
  logic overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic checksum_err;
`endif

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .restart      (restart),
    .bus          (bus.master),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .checksum_err (checksum_err),
`endif
    .cpu_hold     (cpu_hold),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            stamp;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t q_wr[$];
  int  q_acc[$];

  always @(negedge clk) begin
    wr_t w;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) q_acc.push_back(cyc);
      if (bus.mem_we) begin
        w.stamp = cyc;
        w.addr  = bus.mem_addr;
        w.data  = bus.mem_wdata;
        q_wr.push_back(w);
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit ok);
    bit rdy;
    if (gaps) begin
      for (int g = 0; g < 6; g++) begin
        if ($urandom_range(1, 0) == 0) break;
        bus.in_valid = 1'b0;
        step(1);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    for (int t = 0; t < 64; t++) begin
      rdy = bus.in_ready;
      step(1);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] f[$], input bit gaps);
    bit ok;
    foreach (f[i]) begin
      send_byte(f[i], gaps, ok);
      if (!ok) begin
        check("handshake_timeout", 64'd0, 64'd1);
        return;
      end
    end
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] f[$]);
    logic [7:0] x = 8'h00;
    foreach (f[i]) x ^= f[i];
    return x;
  endfunction

  task automatic check_writes(input string tag, input logic [7:0] f[$]);
    int n, nw, m;
    logic [31:0] ew;
    n  = int'(f[0]) + 256 * int'(f[1]);
    nw = (n < DEPTH) ? n : DEPTH;
    check({tag, "_wr_count"}, q_wr.size(), nw);
    m = (q_wr.size() < nw) ? q_wr.size() : nw;
    for (int i = 0; i < m; i++) begin
      ew = {f[4*i+5], f[4*i+4], f[4*i+3], f[4*i+2]};
      check({tag, "_addr"}, q_wr[i].addr, i);
      check({tag, "_data"}, q_wr[i].data, ew);
      if (4*i+5 < q_acc.size())
        check({tag, "_latency"}, q_wr[i].stamp, q_acc[4*i+5] + 1);
      else
        check({tag, "_accept_missing"}, 64'd0, 64'd1);
    end
  endtask

  // Send a complete frame (with checksum byte when that build option is on),
  // then check the done/hold sequencing and the resulting write list.
  task automatic run_frame(input string tag, input logic [7:0] f[$], input bit gaps);
    logic [7:0] tx[$];
    tx = f;
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx.push_back(xsum(f));
`endif
    send_bytes(tx, gaps);
    check({tag, "_done"},        done,         1);
    check({tag, "_hold_entry"},  cpu_hold,     1);
    check({tag, "_ready_done"},  bus.in_ready, 0);
    step(1);
    check({tag, "_hold_release"}, cpu_hold,    0);
    step(2);
    check_writes(tag, f);
  endtask

  task automatic do_restart(input bit with_byte, input logic [7:0] b);
    bus.in_valid = with_byte;
    bus.in_data  = b;
    restart      = 1'b1;
    step(1);
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    q_acc.delete();
    q_wr.delete();
  endtask

  logic [7:0] fr[$];
  int         n_acc0, n_wr0;

  initial begin
    rst          = 1'b1;
    restart      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    step(2);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_mem_we",    bus.mem_we,    0);
    check("rst_mem_addr",  bus.mem_addr,  0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_cpu_hold",  cpu_hold,      1);
    check("rst_done",      done,          0);
    check("rst_overflow",  overflow,      0);
    rst = 1'b0;
    step(1);
    q_acc.delete();
    q_wr.delete();

    // Two-word program, back to back
    fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_frame("two_word", fr, 1'b0);
    if (q_wr.size() == 2) begin
      check("two_word_w0", q_wr[0].data, 32'h0000_0013);
      check("two_word_w1", q_wr[1].data, 32'h0010_0093);
    end

    // Bytes presented in DONE are ignored
    n_acc0 = q_acc.size();
    n_wr0  = q_wr.size();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      step(1);
    end
    bus.in_valid = 1'b0;
    step(2);
    check("done_ignore_acc",  q_acc.size(), n_acc0);
    check("done_ignore_wr",   q_wr.size(),  n_wr0);
    check("done_ignore_done", done,         1);
    check("done_ignore_hold", cpu_hold,     0);

    // Empty image
    do_restart(1'b0, 8'h00);
    check("restart_ready", bus.in_ready, 1);
    check("restart_hold",  cpu_hold,     1);
    check("restart_done",  done,         0);
    fr = '{8'h00, 8'h00};
    run_frame("empty", fr, 1'b0);

    // Header count above DEPTH: 1025 words, the last one discarded
    do_restart(1'b0, 8'h00);
    fr = '{8'h01, 8'h04};
    repeat (4 * 1025) fr.push_back(8'($urandom));
    run_frame("ovf", fr, 1'b0);
    check("ovf_flag", overflow, 1);

    // Restart clears overflow; restart wins over a same-cycle byte
    do_restart(1'b0, 8'h00);
    check("restart_ovf_clear", overflow, 0);
    begin
      bit ok;
      send_byte(8'h01, 1'b0, ok);
      check("prio_first_byte", ok, 1);
    end
    do_restart(1'b1, 8'h07);
    fr = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    run_frame("prio", fr, 1'b0);

    // Three random words with gaps in in_valid
    do_restart(1'b0, 8'h00);
    fr = '{8'h03, 8'h00};
    repeat (12) fr.push_back(8'($urandom));
    run_frame("gaps", fr, 1'b1);

    // Reset in the middle of a word, then a fresh frame
    do_restart(1'b0, 8'h00);
    fr = '{8'h02, 8'h00, 8'hAA, 8'hBB};
    send_bytes(fr, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_ready",  bus.in_ready, 1);
    check("midrst_hold",   cpu_hold,     1);
    check("midrst_mem_we", bus.mem_we,   0);
    step(2);
    rst = 1'b0;
    step(1);
    q_acc.delete();
    q_wr.delete();
    fr = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame("midrst", fr, 1'b0);
    if (q_wr.size() == 1) check("midrst_word", q_wr[0].data, 32'hDEAD_BEEF);

    // Random frames
    for (int k = 0; k < 6; k++) begin
      int n;
      do_restart(1'b0, 8'h00);
      n = $urandom_range(6, 1);
      fr = '{8'(n), 8'h00};
      repeat (4 * n) fr.push_back(8'($urandom));
      run_frame("rand", fr, 1'($urandom_range(1, 0)));
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_restart(1'b0, 8'h00);
    fr = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    send_bytes(fr, 1'b0);
    step(2);
    check("csum_ok_err",  checksum_err, 0);
    check("csum_ok_hold", cpu_hold,     0);
    check("csum_ok_done", done,         1);

    do_restart(1'b0, 8'h00);
    fr = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    send_bytes(fr, 1'b0);
    step(3);
    check("csum_bad_err",  checksum_err, 1);
    check("csum_bad_hold", cpu_hold,     1);
    check("csum_bad_done", done,         1);
    do_restart(1'b0, 8'h00);
    check("csum_restart_err",  checksum_err, 0);
    check("csum_restart_hold", cpu_hold,     1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
